serializador_bits: RTL and testbench

- Parallel-to-serial front end for the serial sequence detector.
- Accepts LARGURA-bit words over a valid/ready handshake.
- Emits one bit per clock on bit_out, which drives the detector's serial input directly.
- bit_valido marks the cycles that carry frame data. Back-to-back words stream with no idle gap.

---
 rtl/serializador_bits.sv | 104 ++++++++++
 tb/tb_serializador_bits.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serializador_bits.sv
// Parallel-to-serial front end feeding the serial sequence detector: LARGURA-bit words in
// over valid/ready, one bit per clock out. Define SERIAL_PARIDADE_EN to append an even-parity bit.
module serializador_bits #(
    parameter int LARGURA      = 8,
    parameter int MSB_PRIMEIRO = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA-1:0] dado,
    input  logic               valido,
    output logic               pronto,
    output logic               bit_out,
    output logic               bit_valido,
    output logic               ocupado
);

`ifdef SERIAL_PARIDADE_EN
    localparam int F = LARGURA + 1;
`else
    localparam int F = LARGURA;
`endif
    localparam int CW = $clog2(F + 1);
    localparam logic [CW-1:0] ULTIMO_IDX = CW'(F - 1);

    typedef enum logic {
        OCIOSO,
        DESLOCA
    } estado_t;

    estado_t       estado_reg, estado_next;
    logic [F-1:0]  desloc_reg, desloc_next;
    logic [CW-1:0] cont_reg, cont_next;
    logic          bit_valido_reg, bit_valido_next;
    logic          ocupado_reg, ocupado_next;

    logic [F-1:0]  carga;
    logic [F-1:0]  deslocado;
    logic          ultimo;
    logic          aceita;

`ifdef SERIAL_PARIDADE_EN
    logic paridade;
    assign paridade = ^dado;
    // Parity rides in the register as the bit shifted out after the data.
    assign carga = (MSB_PRIMEIRO != 0) ? {dado, paridade} : {paridade, dado};
`else
    assign carga = dado;
`endif

    // Zeros are shifted in so the register is empty once the frame has drained.
    assign deslocado = (MSB_PRIMEIRO != 0) ? {desloc_reg[F-2:0], 1'b0}
                                           : {1'b0, desloc_reg[F-1:1]};

    assign ultimo = (estado_reg == DESLOCA) && (cont_reg == ULTIMO_IDX);
    assign pronto = (estado_reg == OCIOSO) || ultimo;
    assign aceita = valido && pronto;

    always_comb begin
        estado_next     = estado_reg;
        desloc_next     = desloc_reg;
        cont_next       = cont_reg;
        bit_valido_next = bit_valido_reg;
        ocupado_next    = ocupado_reg;
        if (aceita) begin
            // Also covers the last-bit reload, giving gap-free back-to-back frames.
            estado_next     = DESLOCA;
            desloc_next     = carga;
            cont_next       = '0;
            bit_valido_next = 1'b1;
            ocupado_next    = 1'b1;
        end else if (ultimo) begin
            estado_next     = OCIOSO;
            desloc_next     = '0;
            cont_next       = '0;
            bit_valido_next = 1'b0;
            ocupado_next    = 1'b0;
        end else if (estado_reg == DESLOCA) begin
            desloc_next = deslocado;
            cont_next   = cont_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg     <= OCIOSO;
            desloc_reg     <= '0;
            cont_reg       <= '0;
            bit_valido_reg <= 1'b0;
            ocupado_reg    <= 1'b0;
        end else begin
            estado_reg     <= estado_next;
            desloc_reg     <= desloc_next;
            cont_reg       <= cont_next;
            bit_valido_reg <= bit_valido_next;
            ocupado_reg    <= ocupado_next;
        end
    end

    // Head of the shift register is a flop bit, and it is zero whenever the line is idle.
    assign bit_out    = (MSB_PRIMEIRO != 0) ? desloc_reg[F-1] : desloc_reg[0];
    assign bit_valido = bit_valido_reg;
    assign ocupado    = ocupado_reg;

endmodule

// File: tb/tb_serializador_bits.sv
// Scoreboard bench for serializador_bits: MSB-first and LSB-first instances, directed words,
// per-cycle handshake/valid checks plus a monitor comparing every serial bit against a queue.
module tb_serializador_bits;

`ifdef SERIAL_PARIDADE_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dado_a, dado_b;
    logic       valido_a, valido_b;
    logic       pronto_a, bit_a, bv_a, oc_a;
    logic       pronto_b, bit_b, bv_b, oc_b;

    logic       q_a[$];
    logic       q_b[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    serializador_bits #(.LARGURA(8), .MSB_PRIMEIRO(1)) dut_a (
        .clk(clk), .rst(rst), .dado(dado_a), .valido(valido_a), .pronto(pronto_a),
        .bit_out(bit_a), .bit_valido(bv_a), .ocupado(oc_a)
    );

    serializador_bits #(.LARGURA(8), .MSB_PRIMEIRO(0)) dut_b (
        .clk(clk), .rst(rst), .dado(dado_b), .valido(valido_b), .pronto(pronto_b),
        .bit_out(bit_b), .bit_valido(bv_b), .ocupado(oc_b)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q_a.push_back(w[7-i]);
`ifdef SERIAL_PARIDADE_EN
        q_a.push_back(^w);
`endif
    endtask

    task automatic push_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q_b.push_back(w[i]);
`ifdef SERIAL_PARIDADE_EN
        q_b.push_back(^w);
`endif
    endtask

    // Monitor: every valid serial bit must be the next expected one; idle line must read 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (bv_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    failures++;
                    $display("FAIL mon_a: got unexpected bit %0b, required no valid bit", bit_a);
                end else begin
                    logic e;
                    e = q_a.pop_front();
                    if (bit_a !== e) begin
                        failures++;
                        $display("FAIL mon_a_bit: got %0b, required %0b", bit_a, e);
                    end
                end
            end else begin
                checks++;
                if (bit_a !== 1'b0) begin
                    failures++;
                    $display("FAIL mon_a_idle: got bit_out=%0b, required 0", bit_a);
                end
            end
            if (bv_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    failures++;
                    $display("FAIL mon_b: got unexpected bit %0b, required no valid bit", bit_b);
                end else begin
                    logic e;
                    e = q_b.pop_front();
                    if (bit_b !== e) begin
                        failures++;
                        $display("FAIL mon_b_bit: got %0b, required %0b", bit_b, e);
                    end
                end
            end
        end
    end

    // Single word on instance A, starting at a negedge with the DUT idle.
    task automatic frame_a(input logic [7:0] w, input string nm);
        chk({nm, "_pronto_idle"}, pronto_a, 1);
        dado_a = w; valido_a = 1'b1; push_a(w);
        @(negedge clk);
        valido_a = 1'b0;
        for (int k = 1; k <= F; k++) begin
            chk($sformatf("%s_bv_c%0d", nm, k), bv_a, 1);
            chk($sformatf("%s_oc_c%0d", nm, k), oc_a, 1);
            chk($sformatf("%s_pronto_c%0d", nm, k), pronto_a, (k == F) ? 1 : 0);
            @(negedge clk);
        end
        chk({nm, "_bv_after"}, bv_a, 0);
        chk({nm, "_oc_after"}, oc_a, 0);
        chk({nm, "_pronto_after"}, pronto_a, 1);
    endtask

    // Two words with valido held; dado shows 'interino' while pronto=0, then w2 from cycle 4.
    task automatic dupla_a(input logic [7:0] w1, input logic [7:0] interino,
                           input logic [7:0] w2, input string nm);
        dado_a = w1; valido_a = 1'b1; push_a(w1); push_a(w2);
        @(negedge clk);
        dado_a = interino;
        for (int k = 1; k <= 2 * F; k++) begin
            if (k == 4) dado_a = w2;
            if (k == F + 1) valido_a = 1'b0;
            chk($sformatf("%s_bv_c%0d", nm, k), bv_a, 1);
            chk($sformatf("%s_pronto_c%0d", nm, k), pronto_a, (k == F || k == 2 * F) ? 1 : 0);
            @(negedge clk);
        end
        chk({nm, "_bv_after"}, bv_a, 0);
        chk({nm, "_pronto_after"}, pronto_a, 1);
    endtask

    initial begin
        rst = 1'b1;
        valido_a = 1'b0; dado_a = 8'h00;
        valido_b = 1'b0; dado_b = 8'h00;
        #1;
        chk("rst_idle_bit", bit_a, 0);
        chk("rst_idle_bv", bv_a, 0);
        chk("rst_idle_oc", oc_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_pronto_a", pronto_a, 1);
        chk("rst_release_pronto_b", pronto_b, 1);
        @(negedge clk);

        frame_a(8'hB4, "b4");
        frame_a(8'h07, "w07");
        dupla_a(8'hF0, 8'h0F, 8'h0F, "b2b");
        dupla_a(8'h3C, 8'h55, 8'hAA, "stall");

        // LSB first on instance B
        chk("lsb_pronto_idle", pronto_b, 1);
        dado_b = 8'h01; valido_b = 1'b1; push_b(8'h01);
        @(negedge clk);
        valido_b = 1'b0;
        for (int k = 1; k <= F; k++) begin
            chk($sformatf("lsb_bv_c%0d", k), bv_b, 1);
            chk($sformatf("lsb_pronto_c%0d", k), pronto_b, (k == F) ? 1 : 0);
            @(negedge clk);
        end
        chk("lsb_bv_after", bv_b, 0);

        // Reset in the middle of a frame of ones aborts it without a clock edge
        dado_a = 8'hFF; valido_a = 1'b1; push_a(8'hFF);
        @(negedge clk);
        valido_a = 1'b0;
        @(negedge clk);
        chk("midrst_bit_before", bit_a, 1);
        #2;
        rst = 1'b1;
        q_a.delete();
        #1;
        chk("midrst_bit", bit_a, 0);
        chk("midrst_bv", bv_a, 0);
        chk("midrst_oc", oc_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_pronto", pronto_a, 1);
        repeat (F + 2) @(negedge clk);
        chk("midrst_bv_stays_idle", bv_a, 0);

        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
